fir_decim_out: RTL
==================

Name: fir_decim_out

Overview:
- Output stage directly downstream of the 21-tap half-band serial FIR.
- Consumes the FIR's 37-bit Q15-gain accumulator output and decimates by DECIM.
- Rounds and shifts back to Q0, then saturates to OUT_WIDTH.
- Buffers results in a small FIFO behind a valid/ready interface for the next consumer.

Parameters:
- IN_WIDTH, 37: width of FIR y_out.
- OUT_WIDTH, 16: output sample width (signed).
- SHIFT, 15: right-shift removing the coefficient scale (FIR DC gain = 2^15).
- DECIM, 2: decimation factor; must be ≥1.
- FIFO_DEPTH, 4: output FIFO entries; must be a power of 2.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- y_in  in  IN_WIDTH  signed FIR output.
- y_valid  in  1  y_in holds a new sample this cycle (FIR x_valid delayed one cycle).
- phase_clr  in  1  resync: the next accepted sample is kept.
- m_data  out  OUT_WIDTH  signed FIFO head.
- m_valid  out  1  FIFO non-empty.
- m_ready  in  1  consumer accepts the head.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- sat_flag  out  1  sticky: a saturation occurred.
- drop_cnt  out  8  count of kept samples lost to a full FIFO; saturates at 255.

Behaviour:
- Reset: rst high at an edge clears phase counter, pipeline valids, FIFO pointers and level, sat_flag and drop_cnt.
  - m_valid=0, m_data=0, fifo_level=0.
  - In-flight samples are discarded; rst asserted mid-operation behaves identically.
- Decimation:
  - phase counter 0..DECIM-1 advances on each y_valid and wraps to 0.
  - A sample is kept when phase==0 at acceptance, so the first sample after reset is kept.
  - phase_clr forces phase to 0 for the next cycle.
  - phase_clr together with y_valid keeps the current sample; phase becomes 1 (0 if DECIM=1).
- Stage 1 (edge k, kept sample): r = (y_in + 2^(SHIFT-1)) >>> SHIFT.
  - Arithmetic shift, rounds half up; intermediate width IN_WIDTH+1, no wrap.
- Stage 2 (edge k+1): clamp r to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
  - Any clamp sets sat_flag, which clears only on rst.
- FIFO write (edge k+2):
  - m_valid is visible after edge k+2 when the FIFO was empty.
  - Latency from y_valid to m_valid is 3 edges.
- FIFO:
  - First-word-fall-through; m_data = head whenever m_valid=1, else held at last value.
  - Pop on m_valid && m_ready.
  - Push and pop in the same cycle when full: both succeed, level unchanged.
  - Push when full without pop: sample dropped, drop_cnt++, FIFO contents unchanged.
  - m_ready while empty is ignored.
  - Pointers wrap modulo FIFO_DEPTH.
- Back-to-back y_valid on every cycle is supported; the pipeline never stalls and does not backpressure the FIR.

Optional Feature:
- Macro FIR_OUT_ROUND_EN.
- Defined: stage 1 adds 2^(SHIFT-1) before shifting (round half up).
- Undefined: pure arithmetic shift (floor truncation). Latency and all other behaviour are unchanged.

Decomposition:
- Package fir_pkg holds:
  - Shared width constants: DATA_WIDTH=16, COEF_WIDTH=16, ACC_WIDTH=37, OUT_SHIFT=15.
  - Default DECIM.
  - A sat_clamp function used by stage 2.
- One sub-module, fir_out_fifo: synchronous FWFT FIFO with push/pop/full/empty/level. It is reused for any later channel.

Test Plan:
- DC tracking: y_in = 1000·2^15 on every cycle with DECIM=2, m_ready=1.
  - m_data = 1000 on every second y_valid.
  - First m_valid 3 edges after the first y_valid.
- Rounding: y_in = 16384 then 49152 (DECIM=1).
  - With FIR_OUT_ROUND_EN: outputs 1, 2.
  - Without FIR_OUT_ROUND_EN: outputs 0, 1.
  - y_in = -16384 gives 0 (round) / -1 (floor).
- Saturation:
  - y_in = 2^31 → 32767, sat_flag=1.
  - y_in = -2^35 → -32768.
  - sat_flag stays 1 until rst.
- Decimation phase:
  - Samples n·2^15, n=1..8, DECIM=2 → outputs 1, 3, 5, 7.
  - Pulsing phase_clr with sample 4 → outputs 1, 3, 4, 6, 8.
- Full/drop: m_ready=0, 12 samples at DECIM=2 (6 kept).
  - fifo_level=4, drop_cnt=2.
  - Then m_ready=1 drains kept samples 1–4 in order.
  - Simultaneous push+pop when full keeps level=4 with no drop.
- Reset mid-stream: rst asserted one edge after y_valid.
  - No output ever appears for that sample.
  - m_valid=0, fifo_level=0, drop_cnt=0 after the edge.

Source files
------------

// File: rtl/fir_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fir_pkg
//  Description : Shared width constants and the saturating clamp helper for
//                the half-band FIR and its output stages.
//  Revision    : 1.0  initial release
// ============================================================================
package fir_pkg;

    localparam int DATA_WIDTH    = 16;
    localparam int COEF_WIDTH    = 16;
    localparam int ACC_WIDTH     = 37;
    localparam int OUT_SHIFT     = 15;
    localparam int DEFAULT_DECIM = 2;

    // Clamp result: saturated value plus a flag telling whether it clipped.
    typedef struct packed {
        logic               sat;
        logic signed [63:0] val;
    } clamp_t;

    // Clamps a signed value to the range of a w-bit two's complement word.
    // Inputs up to 64 bits wide are handled; callers sign-extend first.
    function automatic clamp_t sat_clamp(input logic signed [63:0] v,
                                         input int                 w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        clamp_t             r;
        hi    = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo    = -(64'sd1 <<< (w - 1));
        r.sat = 1'b0;
        r.val = v;
        if (v > hi) begin
            r.val = hi;
            r.sat = 1'b1;
        end else if (v < lo) begin
            r.val = lo;
            r.sat = 1'b1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fir_out_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : fir_out_fifo
//  Description : Synchronous first-word-fall-through FIFO. The head word is
//                held in a register so o_dout keeps its last value while the
//                FIFO is empty. DEPTH must be a power of two (>= 2) so the
//                pointers wrap naturally.
//  Revision    : 1.0  initial release
// ============================================================================
module fir_out_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_din,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_dout,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_level
);

    localparam int c_aw = $clog2(DEPTH);
    localparam int c_lw = c_aw + 1;
    localparam logic [c_lw-1:0] c_full_level = c_lw'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]  r_wr_ptr;
    logic [c_aw-1:0]  r_rd_ptr;
    logic [c_lw-1:0]  r_level;
    logic [WIDTH-1:0] r_dout;

    logic             w_push_ok;
    logic             w_pop_ok;
    logic [c_aw-1:0]  w_rd_next;
    logic [c_lw-1:0]  w_level_next;
    logic [c_lw-1:0]  w_remain;

    assign o_full  = (r_level == c_full_level);
    assign o_empty = (r_level == '0);
    assign o_level = r_level;
    assign o_dout  = r_dout;

    // A pop frees a slot in the same cycle, so a push into a full FIFO
    // succeeds when accompanied by a pop.
    always_comb begin
        w_pop_ok     = i_pop && !o_empty;
        w_push_ok    = i_push && (!o_full || w_pop_ok);
        w_rd_next    = w_pop_ok ? r_rd_ptr + 1'b1 : r_rd_ptr;
        w_remain     = w_pop_ok ? r_level - 1'b1 : r_level;
        w_level_next = r_level;
        if (w_push_ok && !w_pop_ok) begin
            w_level_next = r_level + 1'b1;
        end else if (!w_push_ok && w_pop_ok) begin
            w_level_next = r_level - 1'b1;
        end
    end

    // Storage array; contents need no reset because level gates visibility.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    // Pointers, occupancy and the registered head word.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_dout   <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            r_rd_ptr <= w_rd_next;
            r_level  <= w_level_next;
            // When no older entry survives, the incoming word becomes the head.
            if (w_level_next != '0) begin
                r_dout <= (w_remain == '0) ? i_din : r_mem[w_rd_next];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fir_decim_out.sv
`default_nettype none
// ============================================================================
//  Module      : fir_decim_out
//  Description : Output stage behind the 21-tap half-band serial FIR.
//                Decimates by DECIM, scales the accumulator back to Q0,
//                saturates to OUT_WIDTH and queues results in a FWFT FIFO
//                behind a valid/ready interface. Never stalls the FIR.
//                Build option: FIR_OUT_ROUND_EN selects round-half-up in
//                the scaling stage; otherwise a plain arithmetic shift
//                (floor) is used.
//  Revision    : 1.0  initial release
// ============================================================================
module fir_decim_out
    import fir_pkg::*;
#(
    parameter int IN_WIDTH   = ACC_WIDTH,
    parameter int OUT_WIDTH  = DATA_WIDTH,
    parameter int SHIFT      = OUT_SHIFT,
    parameter int DECIM      = DEFAULT_DECIM,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic signed [IN_WIDTH-1:0]        y_in,
    input  logic                              y_valid,
    input  logic                              phase_clr,
    output logic signed [OUT_WIDTH-1:0]       m_data,
    output logic                              m_valid,
    input  logic                              m_ready,
    output logic [$clog2(FIFO_DEPTH):0]       fifo_level,
    output logic                              sat_flag,
    output logic [7:0]                        drop_cnt
);

    localparam int c_ph_w = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [c_ph_w-1:0] c_ph_last = c_ph_w'(DECIM - 1);
`ifdef FIR_OUT_ROUND_EN
    localparam logic signed [IN_WIDTH:0] c_round = (IN_WIDTH+1)'(1) <<< (SHIFT - 1);
`else
    localparam logic signed [IN_WIDTH:0] c_round = '0;
`endif

    // Decimation phase
    logic [c_ph_w-1:0]        r_phase;
    logic [c_ph_w-1:0]        w_phase_eff;
    logic                     w_keep;

    // Stage 1: scaled sample, full intermediate width so nothing wraps
    logic signed [IN_WIDTH:0] w_ext;
    logic signed [IN_WIDTH:0] w_sum;
    logic signed [IN_WIDTH:0] w_shr;
    logic signed [IN_WIDTH:0] r_s1;
    logic                     r_s1_valid;

    // Stage 2: saturated sample
    clamp_t                   w_clamp;
    logic                     w_unused_clamp_hi;
    logic [OUT_WIDTH-1:0]     r_s2_data;
    logic                     r_s2_valid;
    logic                     r_sat_flag;

    // FIFO side
    logic [OUT_WIDTH-1:0]     w_fifo_dout;
    logic                     w_full;
    logic                     w_empty;
    logic                     w_pop;
    logic                     w_drop;
    logic [7:0]               r_drop_cnt;

    // phase_clr acts on the current cycle, so a sample arriving with it is kept.
    always_comb begin
        w_phase_eff = phase_clr ? '0 : r_phase;
        w_keep      = y_valid && (w_phase_eff == '0);
    end

    // Phase counter: advances per accepted sample, wraps at DECIM-1.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase <= '0;
        end else if (y_valid) begin
            r_phase <= (w_phase_eff == c_ph_last) ? '0 : w_phase_eff + 1'b1;
        end else if (phase_clr) begin
            r_phase <= '0;
        end
    end

    assign w_ext = {y_in[IN_WIDTH-1], y_in};
    assign w_sum = w_ext + c_round;
    assign w_shr = w_sum >>> SHIFT;

    // Stage 1 register: capture the scaled value of kept samples only.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1       <= '0;
            r_s1_valid <= 1'b0;
        end else begin
            r_s1_valid <= w_keep;
            if (w_keep) begin
                r_s1 <= w_shr;
            end
        end
    end

    assign w_clamp           = sat_clamp(64'(r_s1), OUT_WIDTH);
    assign w_unused_clamp_hi = ^w_clamp.val[63:OUT_WIDTH];

    // Stage 2 register: clamp to the output range and latch any clipping.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_data  <= '0;
            r_s2_valid <= 1'b0;
            r_sat_flag <= 1'b0;
        end else begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_data <= w_clamp.val[OUT_WIDTH-1:0];
                if (w_clamp.sat) begin
                    r_sat_flag <= 1'b1;
                end
            end
        end
    end

    fir_out_fifo #(
        .WIDTH (OUT_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (r_s2_valid),
        .i_din   (r_s2_data),
        .i_pop   (m_ready),
        .o_dout  (w_fifo_dout),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (fifo_level)
    );

    // A write is lost only when full and the consumer is not popping.
    assign w_pop  = m_ready && !w_empty;
    assign w_drop = r_s2_valid && w_full && !w_pop;

    // Saturating count of samples lost to a full FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_drop_cnt <= '0;
        end else if (w_drop && (r_drop_cnt != 8'hFF)) begin
            r_drop_cnt <= r_drop_cnt + 8'd1;
        end
    end

    assign m_data   = w_fifo_dout;
    assign m_valid  = !w_empty;
    assign sat_flag = r_sat_flag;
    assign drop_cnt = r_drop_cnt;

endmodule
`default_nettype wire
